// File: rtl/stack_access_ctrl.sv
// Stack sequencer between the stack pointer and the scratch RAM: executes PUSH/POP/CALL/RET.
// Define STACK_GUARD_EN to add occupancy tracking with overflow/underflow reporting on err.
module stack_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 10,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [1:0]        op,
    input  logic [7:0]        reg_data,
    input  logic [DATA_W-1:0] pc_data,
    input  logic [ADDR_W-1:0] sp,
    input  logic [DATA_W-1:0] scr_dout,
    output logic [ADDR_W-1:0] scr_addr,
    output logic [DATA_W-1:0] scr_din,
    output logic              scr_we,
    output logic              sp_incr,
    output logic              sp_decr,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_WR,
        S_POP_RD,
        S_POP_CAP,
        S_FIN,
        S_FAIL
    } state_t;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    state_t            state, state_d;
    logic [DATA_W-1:0] wdata;
    logic              is_ret;
    logic              full, empty;

`ifdef STACK_GUARD_EN
    localparam bit              GUARD  = 1'b1;
    localparam logic [ADDR_W:0] FULL_C = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (state == S_PUSH_WR)
            count <= count + (ADDR_W+1)'(1);
        else if (state == S_POP_CAP)
            count <= count - (ADDR_W+1)'(1);
    end

    assign full  = (count == FULL_C);
    assign empty = (count == '0);
`else
    localparam bit GUARD = 1'b0;

    assign full  = 1'b0;
    assign empty = 1'b0;
`endif

    // NOTE: sequential state uses <= so every register samples pre-edge values;
    // blocking = here would let later statements see already-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            wdata  <= '0;
            is_ret <= 1'b0;
            rdata  <= '0;
        end else begin
            state <= state_d;
            if (state == S_IDLE && op_valid) begin
                is_ret <= (op == OP_RET);
                if (op == OP_PUSH)
                    wdata <= {{(DATA_W-8){1'b0}}, reg_data};
                else if (op == OP_CALL)
                    wdata <= pc_data;
            end
            if (state == S_POP_CAP)
                rdata <= is_ret ? scr_dout : {{(DATA_W-8){1'b0}}, scr_dout[7:0]};
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned
    // (which would infer a latch).
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (op_valid) begin
                    if (op[0])
                        state_d = empty ? S_FAIL : S_POP_RD;
                    else
                        state_d = full ? S_FAIL : S_PUSH_WR;
                end
            end
            S_PUSH_WR: state_d = S_FIN;
            S_POP_RD:  state_d = S_POP_CAP;
            S_POP_CAP: state_d = S_FIN;
            S_FIN:     state_d = S_IDLE;
            S_FAIL:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Side effects are masked by rst so an access aborted mid-flight never lands.
    always_comb begin
        scr_addr = '0;
        scr_we   = 1'b0;
        sp_incr  = 1'b0;
        sp_decr  = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_PUSH_WR: begin
                scr_addr = sp - ADDR_W'(1);
                scr_we   = ~rst;
                sp_decr  = ~rst;
            end
            S_POP_RD:  scr_addr = sp;
            S_POP_CAP: begin
                scr_addr = sp;
                sp_incr  = ~rst;
            end
            S_FIN:     done = 1'b1;
            S_FAIL: begin
                done = 1'b1;
                err  = GUARD;
            end
            default: ;
        endcase
    end

    assign scr_din = wdata;

endmodule

// File: tb/tb_stack_access_ctrl.sv
// Directed bench for stack_access_ctrl: per-cycle vector table plus multi-cycle sequences.
// Guard-specific sequences run when STACK_GUARD_EN is defined.
module tb_stack_access_ctrl;

`ifdef STACK_GUARD_EN
    localparam int DEPTH_TB = 4;
`else
    localparam int DEPTH_TB = 256;
`endif

    logic       clk;
    logic       rst;
    logic       op_valid;
    logic [1:0] op;
    logic [7:0] reg_data;
    logic [9:0] pc_data;
    logic [7:0] sp;
    logic [9:0] scr_dout;
    logic [7:0] scr_addr;
    logic [9:0] scr_din;
    logic       scr_we;
    logic       sp_incr;
    logic       sp_decr;
    logic [9:0] rdata;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    stack_access_ctrl #(.ADDR_W(8), .DATA_W(10), .DEPTH(DEPTH_TB)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .reg_data (reg_data),
        .pc_data  (pc_data),
        .sp       (sp),
        .scr_dout (scr_dout),
        .scr_addr (scr_addr),
        .scr_din  (scr_din),
        .scr_we   (scr_we),
        .sp_incr  (sp_incr),
        .sp_decr  (sp_decr),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ov;
        logic [1:0] op;
        logic [7:0] rd;
        logic [9:0] pc;
        logic [7:0] sp;
        logic [9:0] dout;
        logic [7:0] e_addr;
        logic       e_we;
        logic [9:0] e_din;
        logic       e_incr;
        logic       e_decr;
        logic [9:0] e_rdata;
        logic       e_busy;
        logic       e_done;
        logic       e_err;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t v(
        input logic r, input logic ov, input logic [1:0] o, input logic [7:0] rd,
        input logic [9:0] pc, input logic [7:0] s, input logic [9:0] d,
        input logic [7:0] ea, input logic ew, input logic [9:0] edin, input logic ei,
        input logic ed, input logic [9:0] er, input logic eb, input logic edn, input logic ee);
        vec_t t;
        t.rst = r;   t.ov = ov;     t.op = o;       t.rd = rd;      t.pc = pc;
        t.sp = s;    t.dout = d;    t.e_addr = ea;  t.e_we = ew;    t.e_din = edin;
        t.e_incr = ei; t.e_decr = ed; t.e_rdata = er; t.e_busy = eb;
        t.e_done = edn; t.e_err = ee;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one request from IDLE and follows it to DONE within a bounded number of cycles.
    task automatic run_op(input string name, input logic [1:0] o, input logic [7:0] rd,
                          input logic [9:0] pc, input logic [7:0] s, input logic [9:0] d,
                          input int exp_lat, input logic exp_err,
                          output int n_we, output int n_incr, output int n_decr);
        int   lat;
        logic done_err;
        n_we = 0; n_incr = 0; n_decr = 0; lat = 0; done_err = 1'b0;
        @(negedge clk);
        op_valid = 1'b1; op = o; reg_data = rd; pc_data = pc; sp = s; scr_dout = d;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (scr_we)  n_we++;
            if (sp_incr) n_incr++;
            if (sp_decr) n_decr++;
            if (done) begin
                lat = c;
                done_err = err;
                break;
            end
            @(posedge clk);
        end
        @(negedge clk);
        op_valid = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " err"}, 32'(done_err), 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n_we, n_incr, n_decr;

        rst = 1'b1; op_valid = 1'b0; op = 2'b00; reg_data = '0;
        pc_data = '0; sp = '0; scr_dout = '0;

        //      rst ov op rd     pc      sp     dout     addr  we din     in dc rdata   bs dn er
        tbl[0]  = v(0, 1, 0, 'h15, 'h000, 'h00, 'h000,  'h00, 0, 'h000, 0, 0, 'h000, 0, 0, 0);
        tbl[1]  = v(0, 1, 0, 'h15, 'h000, 'h00, 'h000,  'hFF, 1, 'h015, 0, 1, 'h000, 1, 0, 0);
        tbl[2]  = v(0, 1, 0, 'h15, 'h000, 'hFF, 'h000,  'h00, 0, 'h015, 0, 0, 'h000, 1, 1, 0);
        tbl[3]  = v(0, 1, 1, 'h00, 'h000, 'hFF, 'h000,  'h00, 0, 'h015, 0, 0, 'h000, 0, 0, 0);
        tbl[4]  = v(0, 1, 1, 'h00, 'h000, 'hFF, 'h000,  'hFF, 0, 'h015, 0, 0, 'h000, 1, 0, 0);
        tbl[5]  = v(0, 1, 1, 'h00, 'h000, 'hFF, 'h315,  'hFF, 0, 'h015, 1, 0, 'h000, 1, 0, 0);
        tbl[6]  = v(0, 1, 1, 'h00, 'h000, 'h00, 'h000,  'h00, 0, 'h015, 0, 0, 'h015, 1, 1, 0);
        tbl[7]  = v(0, 1, 2, 'h00, 'h2A7, 'h40, 'h000,  'h00, 0, 'h015, 0, 0, 'h015, 0, 0, 0);
        tbl[8]  = v(0, 1, 2, 'h00, 'h2A7, 'h40, 'h000,  'h3F, 1, 'h2A7, 0, 1, 'h015, 1, 0, 0);
        tbl[9]  = v(0, 1, 2, 'h00, 'h2A7, 'h3F, 'h000,  'h00, 0, 'h2A7, 0, 0, 'h015, 1, 1, 0);
        tbl[10] = v(0, 1, 3, 'h00, 'h000, 'h3F, 'h000,  'h00, 0, 'h2A7, 0, 0, 'h015, 0, 0, 0);
        tbl[11] = v(0, 1, 3, 'h00, 'h000, 'h3F, 'h000,  'h3F, 0, 'h2A7, 0, 0, 'h015, 1, 0, 0);
        tbl[12] = v(0, 1, 3, 'h00, 'h000, 'h3F, 'h2A7,  'h3F, 0, 'h2A7, 1, 0, 'h015, 1, 0, 0);
        tbl[13] = v(0, 1, 3, 'h00, 'h000, 'h40, 'h000,  'h00, 0, 'h2A7, 0, 0, 'h2A7, 1, 1, 0);
        tbl[14] = v(0, 1, 0, 'hAB, 'h000, 'h40, 'h000,  'h00, 0, 'h2A7, 0, 0, 'h2A7, 0, 0, 0);
        tbl[15] = v(0, 0, 1, 'hAB, 'h000, 'h40, 'h000,  'h3F, 1, 'h0AB, 0, 1, 'h2A7, 1, 0, 0);
        tbl[16] = v(0, 1, 1, 'h00, 'h000, 'h3F, 'h000,  'h00, 0, 'h0AB, 0, 0, 'h2A7, 1, 1, 0);
        tbl[17] = v(0, 0, 1, 'h00, 'h000, 'h3F, 'h000,  'h00, 0, 'h0AB, 0, 0, 'h2A7, 0, 0, 0);
        tbl[18] = v(0, 1, 1, 'h00, 'h000, 'h20, 'h000,  'h00, 0, 'h0AB, 0, 0, 'h2A7, 0, 0, 0);
        tbl[19] = v(1, 1, 1, 'h00, 'h000, 'h20, 'h000,  'h20, 0, 'h0AB, 0, 0, 'h2A7, 1, 0, 0);
        tbl[20] = v(0, 0, 1, 'h00, 'h000, 'h20, 'h000,  'h00, 0, 'h000, 0, 0, 'h000, 0, 0, 0);
        tbl[21] = v(0, 1, 0, 'h5A, 'h000, 'h10, 'h000,  'h00, 0, 'h000, 0, 0, 'h000, 0, 0, 0);
        tbl[22] = v(1, 0, 0, 'h5A, 'h000, 'h10, 'h000,  'h0F, 0, 'h05A, 0, 0, 'h000, 1, 0, 0);
        tbl[23] = v(0, 0, 0, 'h00, 'h000, 'h10, 'h000,  'h00, 0, 'h000, 0, 0, 'h000, 0, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset addr",  32'(scr_addr), 32'h0);
        check("reset din",   32'(scr_din),  32'h0);
        check("reset rdata", 32'(rdata),    32'h0);
        check("reset strobes", 32'({scr_we, sp_incr, sp_decr, busy, done, err}), 32'h0);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; op_valid = tbl[i].ov; op = tbl[i].op; reg_data = tbl[i].rd;
            pc_data = tbl[i].pc; sp = tbl[i].sp; scr_dout = tbl[i].dout;
            #1;
            check($sformatf("r%0d addr", i),  32'(scr_addr), 32'(tbl[i].e_addr));
            check($sformatf("r%0d we", i),    32'(scr_we),   32'(tbl[i].e_we));
            check($sformatf("r%0d din", i),   32'(scr_din),  32'(tbl[i].e_din));
            check($sformatf("r%0d incr", i),  32'(sp_incr),  32'(tbl[i].e_incr));
            check($sformatf("r%0d decr", i),  32'(sp_decr),  32'(tbl[i].e_decr));
            check($sformatf("r%0d rdata", i), 32'(rdata),    32'(tbl[i].e_rdata));
            check($sformatf("r%0d busy", i),  32'(busy),     32'(tbl[i].e_busy));
            check($sformatf("r%0d done", i),  32'(done),     32'(tbl[i].e_done));
            check($sformatf("r%0d err", i),   32'(err),      32'(tbl[i].e_err));
        end

`ifdef STACK_GUARD_EN
        // Empty stack after the reset above: POP must fail in one cycle with no side effects.
        run_op("pop empty", 2'b01, 8'h00, 10'h000, 8'h00, 10'h3C5, 1, 1'b1, n_we, n_incr, n_decr);
        check("pop empty incr",  32'(n_incr), 32'd0);
        check("pop empty rdata", 32'(rdata),  32'h0);
        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("push%0d", i), 2'b00, 8'(8'h30 + i), 10'h000, 8'(8'h80 - i),
                   10'h000, (i < 4) ? 2 : 1, (i == 4), n_we, n_incr, n_decr);
            check($sformatf("push%0d we", i),   32'(n_we),   (i < 4) ? 32'd1 : 32'd0);
            check($sformatf("push%0d decr", i), 32'(n_decr), (i < 4) ? 32'd1 : 32'd0);
        end
`else
        // Without the guard an empty POP proceeds and returns the low byte of the RAM word.
        run_op("pop free", 2'b01, 8'h00, 10'h000, 8'h00, 10'h3C5, 3, 1'b0, n_we, n_incr, n_decr);
        check("pop free incr",  32'(n_incr), 32'd1);
        check("pop free we",    32'(n_we),   32'd0);
        check("pop free rdata", 32'(rdata),  32'h0C5);
        run_op("call free", 2'b10, 8'h00, 10'h155, 8'h01, 10'h000, 2, 1'b0, n_we, n_incr, n_decr);
        check("call free decr", 32'(n_decr), 32'd1);
        check("call free din",  32'(scr_din), 32'h155);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_access_ctrl.md
Name: stack_access_ctrl

Overview:
- Sequencer between the stack pointer and the scratch RAM. Executes PUSH, POP, CALL and RET requests from the control unit.
- Generates the scratch RAM address, write enable and write data, and drives the stack pointer's INCR/DECR controls.
- Consumes the stack pointer's OUT value as SP. Returns popped data to the register file or the PC.
- Tracks stack occupancy and flags overflow and underflow.

Parameters:
- ADDR_W, 8, scratch RAM address width and SP width.
- DATA_W, 10, scratch RAM word width, wide enough to hold a PC.
- DEPTH, 256, maximum stack occupancy in words (at most 2**ADDR_W).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- OP_VALID  in  1  request strobe, sampled only in IDLE.
- OP  in  2  operation: 00 PUSH, 01 POP, 10 CALL, 11 RET.
- REG_DATA  in  8  register value for PUSH.
- PC_DATA  in  DATA_W  return address for CALL.
- SP  in  ADDR_W  current stack pointer value (stack pointer OUT).
- SCR_DOUT  in  DATA_W  scratch RAM read data; synchronous read, 1-cycle latency.
- SCR_ADDR  out  ADDR_W  scratch RAM address.
- SCR_DIN  out  DATA_W  scratch RAM write data.
- SCR_WE  out  1  scratch RAM write enable.
- SP_INCR  out  1  stack pointer increment.
- SP_DECR  out  1  stack pointer decrement.
- RDATA  out  DATA_W  popped data; POP gives zero-extended 8 bits, RET gives all 10 bits.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  valid with DONE; 1 = overflow or underflow, operation suppressed.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, including RDATA and SCR_DIN.
  - Occupancy count 0.
  - While RST=1, SCR_WE, SP_INCR and SP_DECR are forced 0.
- States: IDLE, PUSH_WR, POP_RD, POP_CAP, FIN, FAIL. Outputs are Moore-decoded from state; RDATA, SCR_DIN and count are registered.
- IDLE:
  - On OP_VALID=1, latch the write data: PUSH latches {2'b00, REG_DATA}, CALL latches PC_DATA.
  - Latch a 1-bit "is RET" flag.
  - PUSH/CALL go to PUSH_WR, or to FAIL if count==DEPTH.
  - POP/RET go to POP_RD, or to FAIL if count==0.
- PUSH_WR (one cycle):
  - SCR_ADDR=SP-1 (mod 2**ADDR_W), SCR_WE=1, SCR_DIN=latched data, SP_DECR=1.
  - count+1. Next state FIN.
- POP_RD (one cycle): SCR_ADDR=SP, no SP change. Next state POP_CAP.
- POP_CAP (one cycle):
  - RDATA<=SCR_DOUT for RET, or {2'b00, SCR_DOUT[7:0]} for POP.
  - SP_INCR=1, count-1. Next state FIN.
- FIN: DONE=1, ERR=0. Next state IDLE.
- FAIL: DONE=1, ERR=1. No SCR_WE, no SP_INCR/DECR, RDATA unchanged. Next state IDLE.
- Latency from the accepting edge to the DONE cycle:
  - PUSH/CALL: 2 cycles.
  - POP/RET: 3 cycles.
  - Error: 1 cycle.
- OP_VALID while BUSY=1 is ignored; no queueing. The requester holds OP_VALID until it sees DONE.
- SP wrap:
  - From reset (SP=0x00), the first push writes address 0xFF.
  - A pop at SP=0xFF reads 0xFF, and the stack pointer wraps to 0x00.
- SP_INCR and SP_DECR are never asserted in the same cycle.
- The stack pointer's own LD/RST are outside this block. The count is cleared only by RST.
- RST mid-operation: return to IDLE on that edge. The aborted access performs no write and no SP change in the RST cycle. RDATA is cleared.

Optional Feature:
- Macro: STACK_GUARD_EN.
- Defined: occupancy count implemented; overflow/underflow routed to FAIL as above.
- Not defined:
  - No count register; ERR tied 0.
  - PUSH/CALL always go to PUSH_WR and POP/RET always go to POP_RD.
  - SP wraps freely modulo 2**ADDR_W.

Test Plan:
- Reset, then PUSH REG_DATA=0x15 with SP=0x00 -> PUSH_WR cycle shows SCR_ADDR=0xFF, SCR_WE=1, SCR_DIN=0x015, SP_DECR=1; DONE=1, ERR=0 two cycles after acceptance.
- After the push (SP=0xFF), POP with RAM returning 0x315 -> POP_RD shows SCR_ADDR=0xFF; POP_CAP shows SP_INCR=1; DONE with RDATA=0x015.
- CALL PC_DATA=0x2A7 at SP=0x40, then RET -> write at 0x3F, SP_DECR pulse; RET reads 0x3F, RDATA=0x2A7, SP_INCR pulse.
- Guard on: POP from reset -> DONE=1, ERR=1 one cycle after acceptance; no SP_INCR, RDATA=0. DEPTH=4 with five pushes -> fifth gives ERR=1 and SCR_WE never asserted.
- OP_VALID toggled with OP=01 during an active PUSH -> ignored; exactly one DONE, one SP_DECR, and no SP_INCR.
- RST asserted in the POP_RD cycle -> next cycle in IDLE, BUSY=0, DONE=0, no SP_INCR, RDATA=0.
